// File: rtl/seven_seg_pkg.sv
`default_nettype none
// seven_seg_pkg: shared constants and helpers for the multiplexed seven-segment driver.
// Segment bit order is {a,b,c,d,e,f,g}, active low.
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Entry n holds the pattern for hex digit n (entry 15 listed first).
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
      7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
      7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
      7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
   };

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_hex.sv
`default_nettype none
// seven_seg_hex: combinational nibble-to-segment decoder (active-low segments).
module seven_seg_hex
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// seven_seg_scan: time-multiplexed N-digit hex display driver with tear-free
// frame-boundary updates, leading-zero suppression and an anode guard band.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS       = 4,
   parameter int REFRESH_DIV      = 50000,
   parameter int GUARD_CYCLES     = 2,
   parameter int ANODE_ACTIVE_LOW = 1
)
(
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  enable,
   input  logic                                  load,
   input  logic [4*NUM_DIGITS-1:0]               value_in,
   input  logic [NUM_DIGITS-1:0]                 dp_in,
   input  logic                                  blank_lz,
   output logic [6:0]                            seg_out,
   output logic                                  dp_out,
   output logic [NUM_DIGITS-1:0]                 anode,
   output logic [idx_width(NUM_DIGITS)-1:0]      digit_idx,
   output logic                                  frame_done
);

   localparam int IW = idx_width(NUM_DIGITS);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int VW = 4 * NUM_DIGITS;
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
      (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [VW-1:0]         disp_val_q, disp_val_d, pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic                  frame_done_q, frame_done_d;

   logic                  tick, wrap;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  lz_blank;
   logic [NUM_DIGITS-1:0] onehot;
   logic [6:0]            hex_seg;

   seven_seg_hex u_hex (
      .nibble (cur_nib),
      .seg    (hex_seg)
   );

   // Scan counters and the pending/display double buffer.
   always_comb begin
      tick         = enable && (presc_q == PW'(REFRESH_DIV - 1));
      wrap         = tick && (idx_q == IW'(NUM_DIGITS - 1));
      presc_d      = presc_q;
      idx_d        = idx_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_valid_d = pend_valid_q;

      if (enable) presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick)   idx_d   = wrap ? '0 : idx_q + IW'(1);

      if (load && wrap) begin
         disp_val_d   = value_in;
         disp_dp_d    = dp_in;
         pend_valid_d = 1'b0;
      end else if (load) begin
         pend_val_d   = value_in;
         pend_dp_d    = dp_in;
         pend_valid_d = 1'b1;
      end else if (wrap && pend_valid_q) begin
         disp_val_d   = pend_val_q;
         disp_dp_d    = pend_dp_q;
         pend_valid_d = 1'b0;
      end
   end

   // Current-digit select; a digit is a leading zero when it and every digit above are zero.
   always_comb begin
      cur_nib  = 4'h0;
      cur_dp   = 1'b0;
      onehot   = '0;
      lz_blank = blank_lz && (idx_q != '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (int'(idx_q) == k) begin
            cur_nib   = disp_val_q[4*k +: 4];
            cur_dp    = disp_dp_q[k];
            onehot[k] = 1'b1;
         end
         if ((k >= int'(idx_q)) && (disp_val_q[4*k +: 4] != 4'h0)) lz_blank = 1'b0;
      end
   end

   always_comb begin
      seg_d        = SEG_BLANK;
      dp_d         = 1'b1;
      anode_d      = ANODE_OFF;
      frame_done_d = wrap;
      if (enable) begin
         seg_d = lz_blank ? SEG_BLANK : hex_seg;
         dp_d  = ~cur_dp;
         if (int'(presc_q) >= GUARD_CYCLES)
            anode_d = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         idx_q        <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_valid_q <= 1'b0;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         anode_q      <= ANODE_OFF;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_valid_q <= pend_valid_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         anode_q      <= anode_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign anode      = anode_q;
   assign digit_idx  = idx_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire
